// File: rtl/uart_receive.sv
// 8N1 UART receiver, LSB first, oversampled by the system clock, with valid/ack delivery.
// Optional stop-bit checking is enabled by defining UART_RX_FRAMING_CHECK_EN.
module uart_receive #(
  parameter int clockperbit = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  input  logic       rxack,
  output logic [7:0] rxdata,
  output logic       rxvalid,
  output logic       overrun,
  output logic       framing_err
);

  localparam int TW = $clog2(clockperbit) + 1;
  localparam logic [TW-1:0] HALF_LOAD = TW'(clockperbit / 2 - 1);
  localparam logic [TW-1:0] BIT_LOAD  = TW'(clockperbit - 1);
  localparam logic [TW-1:0] TIMER_ZERO = {TW{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    index_q, index_d;
  logic [7:0]    shift_q, shift_d;
  logic          armed_q, armed_d;
  logic [7:0]    rxdata_q, rxdata_d;
  logic          rxvalid_q, rxvalid_d;
  logic          overrun_q, overrun_d;
  logic          ferr_q, ferr_d;
  logic          deliver_s;
  logic          rx_s;

  assign rx_s = sync2_q;

  // Next-state, timing and delivery logic for the receive FSM.
  always_comb begin
    sync1_d   = rx;
    sync2_d   = sync1_q;
    state_d   = state_q;
    timer_d   = timer_q;
    index_d   = index_q;
    shift_d   = shift_q;
    armed_d   = armed_q;
    rxdata_d  = rxdata_q;
    overrun_d = overrun_q;
    ferr_d    = 1'b0;
    deliver_s = 1'b0;

    if (rxack) begin
      rxvalid_d = 1'b0;
    end else begin
      rxvalid_d = rxvalid_q;
    end

    case (state_q)
      IDLE: begin
        // A start needs a high-to-low transition, so a held-low line never re-arms.
        if (!rx_s && armed_q) begin
          state_d = START;
          timer_d = HALF_LOAD;
          armed_d = 1'b0;
        end else if (rx_s) begin
          armed_d = 1'b1;
        end else begin
          armed_d = armed_q;
        end
      end
      START: begin
        if (timer_q != TIMER_ZERO) begin
          timer_d = timer_q - TW'(1);
        end else if (rx_s) begin
          state_d = IDLE;
          armed_d = 1'b1;
        end else begin
          state_d = DATA;
          index_d = 3'd0;
          timer_d = BIT_LOAD;
        end
      end
      DATA: begin
        if (timer_q != TIMER_ZERO) begin
          timer_d = timer_q - TW'(1);
        end else begin
          shift_d[index_q] = rx_s;
          timer_d = BIT_LOAD;
          if (index_q == 3'd7) begin
            state_d = STOP;
          end else begin
            index_d = index_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (timer_q != TIMER_ZERO) begin
          timer_d = timer_q - TW'(1);
        end else begin
          state_d = IDLE;
          armed_d = rx_s;
          if (rx_s) begin
            deliver_s = 1'b1;
          end else begin
`ifdef UART_RX_FRAMING_CHECK_EN
            ferr_d = 1'b1;
`else
            deliver_s = 1'b1;
`endif
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Delivery outranks a same-cycle ack; only an unacked full buffer is an overrun.
    if (deliver_s) begin
      rxdata_d  = shift_q;
      rxvalid_d = 1'b1;
      if (rxvalid_q && !rxack) begin
        overrun_d = 1'b1;
      end else begin
        overrun_d = overrun_q;
      end
    end else begin
      rxdata_d = rxdata_q;
    end
  end

  // State and output registers; the synchronizer resets to the idle line level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      timer_q   <= TIMER_ZERO;
      index_q   <= 3'd0;
      shift_q   <= 8'h00;
      armed_q   <= 1'b0;
      rxdata_q  <= 8'h00;
      rxvalid_q <= 1'b0;
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      timer_q   <= timer_d;
      index_q   <= index_d;
      shift_q   <= shift_d;
      armed_q   <= armed_d;
      rxdata_q  <= rxdata_d;
      rxvalid_q <= rxvalid_d;
      overrun_q <= overrun_d;
      ferr_q    <= ferr_d;
    end
  end

  assign rxdata      = rxdata_q;
  assign rxvalid     = rxvalid_q;
  assign overrun     = overrun_q;
  assign framing_err = ferr_q;

endmodule
